// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings, control-word layout, FSM states and scoreboard entry for the hazard controller.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam int CW_MEMREAD  = 8;
  localparam int CW_REGDST   = 5;
  localparam int CW_REGWRITE = 0;
  // {MemRead, MemWrite, ALUSrc, RegDst, ALUop[2:0], MemtoReg, RegWrite}
  localparam logic [8:0] CW_LW   = 9'b1_0_1_1_010_1_1;
  localparam logic [8:0] CW_SW   = 9'b0_1_1_0_010_0_0;
  localparam logic [8:0] CW_ADDI = 9'b0_0_1_1_010_0_1;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       regwrite;
    logic       memread;
  } sb_t;
  function automatic logic writes(sb_t e, logic [4:0] r);
    return e.regwrite && e.dest != 5'd0 && e.dest == r;
  endfunction
endpackage

// File: rtl/main_decoder.sv
// main_decoder: maps the IF/ID instruction to the 9-bit pipeline control word.
module main_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [8:0]  ControlOutput
);
  logic [5:0] op;
  logic [5:0] funct;
  logic [2:0] alu;
  logic       known;
  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign known = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign alu   = funct == F_SUB ? ALU_SUB :
                 funct == F_AND ? ALU_AND :
                 funct == F_OR  ? ALU_OR  :
                 funct == F_SLT ? ALU_SLT : ALU_ADD;
  always_comb
    ControlOutput = instruction == 32'd0 ? 9'd0 :
                    op == OP_RTYPE ? (known ? {4'b0000, alu, 2'b01} : 9'd0) :
                    op == OP_LW    ? CW_LW :
                    op == OP_SW    ? CW_SW :
                    op == OP_ADDI  ? CW_ADDI : 9'd0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch stall, forwarding select, flush control and perf counters for a 5-stage MIPS pipe.
module pipe_hazard_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        eq,
  output logic [8:0]  ControlOutput,
  output logic        HazardSel,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        PCSrc,
  output logic        IF_Flush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);
  logic [8:0] cw;
  logic [4:0] rs, rt, rd, dest;
  logic       is_beq, uses_rt, load_use, br_stall, stall, taken, go;
  sb_t        id_e, ex, mem, wb;
  state_t     state, state_n;
  main_decoder u_dec (.instruction(instruction), .ControlOutput(cw));
  assign ControlOutput = cw;
  assign rs      = instruction[25:21];
  assign rt      = instruction[20:16];
  assign rd      = instruction[15:11];
  assign dest    = cw[CW_REGDST] ? rt : rd;
  assign is_beq  = instruction[31:26] == OP_BEQ;
  assign uses_rt = (instruction[31:26] == OP_RTYPE && instruction != 32'd0) || instruction[31:26] == OP_SW || is_beq;
  assign id_e    = '{rs: rs, rt: rt, dest: dest, regwrite: cw[CW_REGWRITE], memread: cw[CW_MEMREAD]};
  assign load_use = ex.memread && ex.dest != 5'd0 && (ex.dest == rs || (uses_rt && ex.dest == rt));
  assign br_stall = is_beq && (writes(ex, rs) || writes(ex, rt) || writes(mem, rs) ||
                               writes(mem, rt) || writes(wb, rs) || writes(wb, rt));
  assign stall = load_use || br_stall;
  // A stall holds the branch in ID, so it can never be taken in the same cycle.
  assign taken = is_beq && eq && !stall;
  assign go    = !rst && !stall;
  assign PCWrite    = go;
  assign IF_IDWrite = go;
  assign HazardSel  = go;
  assign PCSrc      = !rst && taken;
  assign IF_Flush   = !rst && taken;
  assign ForwardA = rst ? 2'b00 : writes(mem, ex.rs) ? 2'b01 : writes(wb, ex.rs) ? 2'b10 : 2'b00;
  assign ForwardB = rst ? 2'b00 : writes(mem, ex.rt) ? 2'b01 : writes(wb, ex.rt) ? 2'b10 : 2'b00;
  always_comb
    state_n = stall ? STALL : (state == RUN && taken) ? FLUSH : RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex          <= '0;
      mem         <= '0;
      wb          <= '0;
      stall_count <= '0;
      flush_count <= '0;
      state       <= RUN;
    end else begin
      ex          <= stall ? '0 : id_e;
      mem         <= ex;
      wb          <= mem;
      stall_count <= stall_count + {15'd0, stall && stall_count != 16'hFFFF};
      flush_count <= flush_count + {15'd0, taken && flush_count != 16'hFFFF};
      state       <= state_n;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: decode vector table, directed hazard sequences and random stimulus against a queue-based pipeline model.
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        eq = 1'b0;
  logic [8:0]  ControlOutput;
  logic        HazardSel, PCWrite, IF_IDWrite, PCSrc, IF_Flush;
  logic [1:0]  ForwardA, ForwardB;
  logic [15:0] stall_count, flush_count;
  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .eq(eq),
    .ControlOutput(ControlOutput), .HazardSel(HazardSel), .PCWrite(PCWrite),
    .IF_IDWrite(IF_IDWrite), .PCSrc(PCSrc), .IF_Flush(IF_Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'd0, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  // Reference decode straight from the instruction table.
  function automatic logic [8:0] ref_cw(input logic [31:0] i);
    if (i == 32'd0) return 9'd0;
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h20: return 9'b0_0_0_0_010_0_1;
               6'h22: return 9'b0_0_0_0_110_0_1;
               6'h24: return 9'b0_0_0_0_000_0_1;
               6'h25: return 9'b0_0_0_0_001_0_1;
               6'h2A: return 9'b0_0_0_0_111_0_1;
               default: return 9'd0;
             endcase
      6'h23: return 9'b1_0_1_1_010_1_1;
      6'h2B: return 9'b0_1_1_0_010_0_0;
      6'h08: return 9'b0_0_1_1_010_0_1;
      default: return 9'd0;
    endcase
  endfunction

  typedef struct {logic [4:0] rs, rt, dst; bit wr, ld;} ent_t;
  ent_t   pipe[$];
  logic [15:0] m_stall, m_flush;
  state_t m_state;
  ent_t   m_next;
  bit     m_st, m_tk;

  function automatic logic [1:0] fwd(input logic [4:0] r);
    if (r != 0 && pipe[1].wr && pipe[1].dst == r) return 2'b01;
    if (r != 0 && pipe[2].wr && pipe[2].dst == r) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    ent_t z = '{rs: 0, rt: 0, dst: 0, wr: 0, ld: 0};
    pipe.delete();
    repeat (3) pipe.push_back(z);
    m_stall = 0;
    m_flush = 0;
    m_state = RUN;
  endtask

  task automatic dc(input logic [31:0] ins, input logic e);
    logic [8:0] cw;
    logic [4:0] s, t, d;
    bit beq, urt, lu, bs;
    @(negedge clk);
    instruction = ins;
    eq = e;
    #1;
    cw  = ref_cw(ins);
    s   = ins[25:21];
    t   = ins[20:16];
    d   = cw[5] ? t : ins[15:11];
    beq = ins[31:26] == 6'h04;
    urt = (ins[31:26] == 6'h00 && ins != 0) || ins[31:26] == 6'h2B || beq;
    lu  = pipe[0].ld && pipe[0].dst != 0 && (pipe[0].dst == s || (urt && pipe[0].dst == t));
    bs  = 0;
    for (int k = 0; k < 3; k++)
      if (beq && pipe[k].wr && pipe[k].dst != 0 && (pipe[k].dst == s || pipe[k].dst == t)) bs = 1;
    m_st = lu || bs;
    m_tk = beq && e && !m_st;
    m_next = m_st ? '{rs: 0, rt: 0, dst: 0, wr: 0, ld: 0} : '{rs: s, rt: t, dst: d, wr: cw[0], ld: cw[8]};
    chk("cw", ControlOutput, cw);
    chk("PCWrite", PCWrite, !m_st);
    chk("IF_IDWrite", IF_IDWrite, !m_st);
    chk("HazardSel", HazardSel, !m_st);
    chk("PCSrc", PCSrc, m_tk);
    chk("IF_Flush", IF_Flush, m_tk);
    chk("ForwardA", ForwardA, fwd(pipe[0].rs));
    chk("ForwardB", ForwardB, fwd(pipe[0].rt));
    chk("stall_count", stall_count, m_stall);
    chk("flush_count", flush_count, m_flush);
    chk("state", dut.state, m_state);
  endtask

  task automatic adv();
    @(posedge clk);
    void'(pipe.pop_back());
    pipe.push_front(m_next);
    if (m_st && m_stall != 16'hFFFF) m_stall++;
    if (m_tk && m_flush != 16'hFFFF) m_flush++;
    m_state = m_st ? STALL : (m_state == RUN && m_tk) ? FLUSH : RUN;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instruction = 32'd0;
    eq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] fn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
    logic [4:0] a = 5'($urandom_range(0, 3));
    logic [4:0] b = 5'($urandom_range(0, 3));
    logic [4:0] c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1: return r_ins(fn[$urandom_range(0, 5)], c, a, b);
      2:    return i_ins(6'h23, a, b, 16'd4);
      3:    return i_ins(6'h2B, a, b, 16'd8);
      4:    return i_ins(6'h08, a, b, 16'd7);
      5:    return i_ins(6'h04, a, b, 16'd2);
      6:    return 32'd0;
      default: return i_ins(6'h02, a, b, 16'd1);
    endcase
  endfunction

  typedef struct {string name; logic [31:0] ins; logic [8:0] cw;} vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{"add",   r_ins(6'h20, 5'd3, 5'd1, 5'd2), 9'h009};
    tbl[1]  = '{"sub",   r_ins(6'h22, 5'd3, 5'd1, 5'd2), 9'h019};
    tbl[2]  = '{"and",   r_ins(6'h24, 5'd3, 5'd1, 5'd2), 9'h001};
    tbl[3]  = '{"or",    r_ins(6'h25, 5'd3, 5'd1, 5'd2), 9'h005};
    tbl[4]  = '{"slt",   r_ins(6'h2A, 5'd3, 5'd1, 5'd2), 9'h01D};
    tbl[5]  = '{"lw",    i_ins(6'h23, 5'd1, 5'd2, 16'd0), 9'h16B};
    tbl[6]  = '{"sw",    i_ins(6'h2B, 5'd1, 5'd2, 16'd4), 9'h0C8};
    tbl[7]  = '{"addi",  i_ins(6'h08, 5'd0, 5'd5, 16'd7), 9'h069};
    tbl[8]  = '{"beq",   i_ins(6'h04, 5'd1, 5'd1, 16'd3), 9'h000};
    tbl[9]  = '{"zero",  32'd0, 9'h000};
    tbl[10] = '{"badop", i_ins(6'h02, 5'd1, 5'd2, 16'd9), 9'h000};
    tbl[11] = '{"badfn", r_ins(6'h08, 5'd0, 5'd31, 5'd0), 9'h000};
    model_reset();
    for (int i = 0; i < 12; i++) begin
      instruction = tbl[i].ins;
      #1;
      chk({"dec_", tbl[i].name}, ControlOutput, tbl[i].cw);
    end
    instruction = i_ins(6'h04, 5'd1, 5'd1, 16'd3);
    eq = 1'b1;
    #1;
    chk("rst_PCWrite", PCWrite, 0);
    chk("rst_IF_IDWrite", IF_IDWrite, 0);
    chk("rst_HazardSel", HazardSel, 0);
    chk("rst_PCSrc", PCSrc, 0);
    chk("rst_IF_Flush", IF_Flush, 0);
    chk("rst_ForwardA", ForwardA, 0);
    chk("rst_ForwardB", ForwardB, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);

    do_reset();
    dc(i_ins(6'h23, 5'd1, 5'd2, 16'd0), 0); adv();
    dc(r_ins(6'h20, 5'd3, 5'd2, 5'd4), 0);
    chk("lu_HazardSel", HazardSel, 0);
    chk("lu_PCWrite", PCWrite, 0);
    adv();
    dc(r_ins(6'h20, 5'd3, 5'd2, 5'd4), 0);
    chk("lu_stall_count", stall_count, 1);
    chk("lu_release", HazardSel, 1);
    adv();
    dc(32'd0, 0);
    chk("lu_ForwardA", ForwardA, 2'b10);
    adv();

    do_reset();
    dc(r_ins(6'h20, 5'd2, 5'd1, 5'd1), 0); adv();
    dc(r_ins(6'h22, 5'd3, 5'd2, 5'd2), 0);
    chk("rr_nostall", HazardSel, 1);
    adv();
    dc(32'd0, 0);
    chk("rr_ForwardA", ForwardA, 2'b01);
    chk("rr_ForwardB", ForwardB, 2'b01);
    adv();

    do_reset();
    dc(i_ins(6'h04, 5'd1, 5'd1, 16'd3), 1);
    chk("br_PCSrc", PCSrc, 1);
    chk("br_IF_Flush", IF_Flush, 1);
    adv();
    dc(32'd0, 0);
    chk("br_flush_count", flush_count, 1);
    chk("br_state_flush", dut.state, FLUSH);
    adv();
    dc(32'd0, 0);
    chk("br_state_run", dut.state, RUN);
    adv();

    do_reset();
    dc(i_ins(6'h08, 5'd0, 5'd5, 16'd7), 0); adv();
    for (int k = 0; k < 3; k++) begin
      dc(i_ins(6'h04, 5'd5, 5'd6, 16'd3), 1);
      chk("bs_HazardSel", HazardSel, 0);
      chk("bs_PCSrc", PCSrc, 0);
      adv();
    end
    dc(i_ins(6'h04, 5'd5, 5'd6, 16'd3), 1);
    chk("bs_taken", PCSrc, 1);
    chk("bs_stall_count", stall_count, 3);
    adv();

    do_reset();
    dc(r_ins(6'h20, 5'd0, 5'd1, 5'd1), 0); adv();
    dc(r_ins(6'h20, 5'd3, 5'd0, 5'd0), 0);
    chk("r0_nostall", HazardSel, 1);
    adv();
    dc(32'd0, 0);
    chk("r0_ForwardA", ForwardA, 0);
    chk("r0_ForwardB", ForwardB, 0);
    adv();

    do_reset();
    @(negedge clk);
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    m_stall = 16'hFFFE;
    dc(i_ins(6'h08, 5'd0, 5'd5, 16'd7), 0); adv();
    for (int k = 0; k < 3; k++) begin
      dc(i_ins(6'h04, 5'd5, 5'd5, 16'd3), 0);
      adv();
    end
    dc(32'd0, 0);
    chk("sat_stall_count", stall_count, 16'hFFFF);
    adv();
    dc(i_ins(6'h08, 5'd0, 5'd5, 16'd7), 0); adv();
    dc(i_ins(6'h04, 5'd5, 5'd5, 16'd3), 1);
    chk("mid_stall", HazardSel, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_PCWrite", PCWrite, 0);
    chk("async_HazardSel", HazardSel, 0);
    chk("async_PCSrc", PCSrc, 0);
    chk("async_IF_Flush", IF_Flush, 0);
    chk("async_ForwardA", ForwardA, 0);
    chk("async_stall_count", stall_count, 0);
    chk("async_flush_count", flush_count, 0);
    chk("async_state", dut.state, RUN);
    do_reset();
    dc(i_ins(6'h04, 5'd5, 5'd5, 16'd3), 1);
    chk("post_rst_taken", PCSrc, 1);
    adv();

    do_reset();
    for (int n = 0; n < 600; n++) begin
      dc(rand_ins(), 1'($urandom_range(0, 1)));
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline datapath.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instruction  input  32  instruction currently held in IF/ID.
REQ-005 eq  input  1  ID-stage register comparator result, 1 = rs value equals rt value.
REQ-006 ControlOutput  output  9  control word {MemRead, MemWrite, ALUSrc, RegDst, ALUop[2:0], MemtoReg, RegWrite}, bits 8..0.
REQ-007 HazardSel  output  1  0 inserts a bubble (zero control word) into ID/EX; 1 passes ControlOutput.
REQ-008 PCWrite, IF_IDWrite  output  1 each  load enables for the PC and IF/ID registers.
REQ-009 PCSrc  output  1  1 selects the branch target for the PC.
REQ-010 IF_Flush  output  1  1 clears IF/ID on the next edge.
REQ-011 ForwardA, ForwardB  output  2 each  EX operand select: 00 = register file, 01 = EX/MEM ALU result, 10 = WB data.
REQ-012 stall_count, flush_count  output  16 each  saturating performance counters.

Function
REQ-013 Decode SHALL drive ControlOutput as follows:
- R-type (op 000000, instruction nonzero): funct 100000/100010/100100/100101/101010 map to ALUop 010/110/000/001/111; RegWrite=1; all other bits 0.
- lw (100011): MemRead=1, ALUSrc=1, RegDst=1, ALUop=010, MemtoReg=1, RegWrite=1.
- sw (101011): MemWrite=1, ALUSrc=1, ALUop=010.
- addi (001000): ALUSrc=1, RegDst=1, ALUop=010, RegWrite=1.
- beq (000100), all-zero instruction, unknown op and unknown funct: 9'b0.
REQ-014 The destination register SHALL be rt when RegDst=1 and rd otherwise; register 0 SHALL never count as a hazard or forwarding source.
REQ-015 Shadow scoreboard: on each clk edge the block SHALL shift {rs, rt, dest, RegWrite, MemRead} through EX, MEM and WB stages.
- The EX entry SHALL be zeroed whenever HazardSel=0.
REQ-016 Load-use stall: the ID instruction's rs, or its rt (R-type, sw and beq only), equals EX dest while EX MemRead=1. Response: PCWrite=0, IF_IDWrite=0, HazardSel=0.
REQ-017 Branch stall: beq rs or rt matches a RegWrite dest in EX, MEM or WB. Response is the same as REQ-016, and PCSrc SHALL be 0 during the stall.
REQ-018 With no stall, PCWrite=IF_IDWrite=HazardSel=1 and PCSrc=IF_Flush=(beq AND eq), combinationally in the same cycle.
REQ-019 ForwardA SHALL be 01 when MEM RegWrite=1 and MEM dest equals EX rs, else 10 when WB RegWrite=1 and WB dest equals EX rs, else 00. MEM SHALL take priority when both match.
REQ-020 ForwardB SHALL follow the same rule as REQ-019 using EX rt.
REQ-021 State machine states SHALL be RUN, STALL and FLUSH.
- RUN goes to STALL on any stall condition and to FLUSH on a taken branch.
- STALL stays in STALL while a stall condition persists, otherwise returns to RUN.
- FLUSH SHALL last exactly one cycle, then go to RUN, or to STALL if a stall condition is present.
REQ-022 stall_count SHALL increment on every edge at which HazardSel=0. flush_count SHALL increment on every edge at which IF_Flush=1. Both SHALL saturate at 16'hFFFF with no wrap-around.
REQ-023 Load-use stall and taken branch SHALL be mutually exclusive because a stall forces PCSrc=0; the stall SHALL win.

Reset
REQ-024 While rst=1 the block SHALL drive PCWrite=0, IF_IDWrite=0, HazardSel=0, PCSrc=0, IF_Flush=0 and ForwardA=ForwardB=00.
REQ-025 While rst=1 the scoreboard, both counters and the state machine SHALL be cleared, with the state machine in RUN.
REQ-026 Reset asserted mid-stall or mid-flush SHALL abort it immediately; the first edge after deassertion SHALL behave as RUN with an empty scoreboard.

Structure
REQ-027 Opcode, funct and ALUop encodings, control-word bit indices and state encodings SHALL live in a shared package, mips_pkg.
REQ-028 Decode SHALL be a sub-module, main_decoder (instruction to 9-bit word). Scoreboard, forwarding, hazard logic and counters SHALL stay in the top module.

Verification
REQ-029 Sequence lw $2,0($1) then add $3,$2,$4 -> one cycle with PCWrite=IF_IDWrite=HazardSel=0; stall_count=1; then ForwardA=10 for the add in EX.
REQ-030 Sequence add $2,$1,$1 then sub $3,$2,$2 -> no stall; ForwardA=ForwardB=01 when sub is in EX.
REQ-031 beq $1,$1 with eq=1 and no dependencies -> PCSrc=IF_Flush=1 for one cycle; flush_count=1; state goes FLUSH then RUN.
REQ-032 Sequence addi $5,$0,7 then beq $5,$6 -> beq stalls 3 cycles (dest in EX, MEM, WB); PCSrc stays 0 until the stall clears.
REQ-033 add $0,$1,$1 followed by a reader of $0 -> Forward=00 and no stall.
REQ-034 Force stall_count to 16'hFFFE, then 3 stalls -> count reads FFFF. Assert rst during a stall -> all outputs 0 and counters 0 asynchronously.
